// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer/FIFO-side signal bundle of the round-robin write arbiter
// master = producers and FIFO side, slave = the arbiter itself.
interface fifo_wr_arbiter_if #(
    parameter int DATA = 14,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [NREQ*DATA-1:0] req_data;
    logic [NREQ-1:0]      req_last;
    logic                 fifo_full;
    logic                 fifo_w_en;
    logic [DATA-1:0]      fifo_data_in;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic [15:0]          wr_count;

    modport master (
        output req, req_data, req_last, fifo_full,
        input  fifo_w_en, fifo_data_in, ack, grant, busy, wr_count
    );

    modport slave (
        input  req, req_data, req_last, fifo_full,
        output fifo_w_en, fifo_data_in, ack, grant, busy, wr_count
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the async FIFO write port
// One owner at a time, bounded bursts, every word gated by fifo_full.
module fifo_wr_arbiter #(
    parameter int DATA      = 14,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             wclk,
    input  logic             rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   own, own_n;
    logic [IW-1:0]   last, last_n;
    logic [IW-1:0]   pick, idx;
    logic [BW-1:0]   beat, beat_n;
    logic [NREQ-1:0] grant_q, grant_n;
    logic [15:0]     wr_count, wr_count_n;
    logic            found;
    logic            xfer;

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            own      <= '0;
            last     <= IW'(NREQ - 1);
            beat     <= '0;
            grant_q  <= '0;
            wr_count <= '0;
        end else begin
            state    <= state_n;
            own      <= own_n;
            last     <= last_n;
            beat     <= beat_n;
            grant_q  <= grant_n;
            wr_count <= wr_count_n;
        end
    end

    // First requester strictly after the previous owner, wrapping around.
    always_comb begin
        pick  = last;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last) + k) % NREQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_n          = state;
        own_n            = own;
        last_n           = last;
        beat_n           = beat;
        grant_n          = grant_q;
        wr_count_n       = wr_count;
        xfer             = 1'b0;
        bus.fifo_w_en    = 1'b0;
        bus.fifo_data_in = '0;
        bus.ack          = '0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_n = GRANT;
                    own_n   = pick;
                    grant_n = NREQ'(1) << pick;
                    beat_n  = '0;
                end
            end
            GRANT: begin
                bus.fifo_data_in = bus.req_data[int'(own)*DATA +: DATA];
                // rst term keeps the write port quiet for the whole reset pulse.
                xfer          = bus.req[own] & ~bus.fifo_full & ~rst;
                bus.fifo_w_en = xfer;
                if (xfer) begin
                    bus.ack    = NREQ'(1) << own;
                    beat_n     = beat + BW'(1);
                    wr_count_n = wr_count + 16'd1;
                end
                if (!bus.req[own] ||
                    (xfer && (bus.req_last[own] || ((beat + BW'(1)) == BW'(MAX_BURST))))) begin
                    state_n = IDLE;
                    last_n  = own;
                    grant_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.grant    = grant_q;
    assign bus.busy     = (state == GRANT);
    assign bus.wr_count = wr_count;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
// Producer driver feeds per-requester queues; a negedge monitor pops expected words.
module tb_fifo_wr_arbiter;
    localparam int DATA = 14;
    localparam int NREQ = 4;
    localparam int MB   = 4;

    typedef struct {
        logic [DATA-1:0] d;
        logic            l;
    } word_t;

    typedef struct {
        int              idx;
        logic [DATA-1:0] d;
    } exp_t;

    logic wclk  = 1'b0;
    logic rst   = 1'b1;
    logic rst_w = 1'b1;
    always #5 wclk = ~wclk;

    fifo_wr_arbiter_if #(.DATA(DATA), .NREQ(NREQ)) bus ();
    fifo_wr_arbiter #(.DATA(DATA), .NREQ(NREQ), .MAX_BURST(MB)) dut (
        .wclk(wclk), .rst(rst), .bus(bus)
    );

    // Second instance with long bursts, used only to reach the counter wrap quickly.
    fifo_wr_arbiter_if #(.DATA(DATA), .NREQ(NREQ)) wbus ();
    fifo_wr_arbiter #(.DATA(DATA), .NREQ(NREQ), .MAX_BURST(15)) dut_w (
        .wclk(wclk), .rst(rst_w), .bus(wbus)
    );
    assign wbus.req       = 4'b0001;
    assign wbus.req_data  = '0;
    assign wbus.req_last  = '0;
    assign wbus.fifo_full = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_req = 0;
    int wn    = 0;
    bit wrap_done = 1'b0;

    word_t           src[NREQ][$];
    exp_t            exp_q[$];
    int              stamps[$];
    logic [NREQ-1:0] en    = '0;
    logic [NREQ-1:0] ack_s = '0;

    always @(posedge wclk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(int i, logic [DATA-1:0] d, logic l, logic e);
        word_t w;
        exp_t  x;
        w.d = d;
        w.l = l;
        src[i].push_back(w);
        if (e) begin
            x.idx = i;
            x.d   = d;
            exp_q.push_back(x);
        end
    endtask

    task automatic wait_writes(string name, int n, int budget);
        while (stamps.size() < n && budget > 0) begin
            @(negedge wclk);
            #1;
            budget--;
        end
        check({name, "_timeout"}, 32'(stamps.size() >= n), 32'd1);
    endtask

    task automatic check_offs(string name, int n, int off[8]);
        for (int j = 0; j < n; j++)
            if (j < stamps.size())
                check(name, 32'(stamps[j] - stamps[0]), 32'(off[j]));
    endtask

    task automatic settle(string name);
        repeat (4) @(negedge wclk);
        #1;
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_idle"}, 32'(bus.busy), 32'd0);
        stamps.delete();
    endtask

    // Producer driver: retire acked words, then present each queue head.
    initial begin
        logic [NREQ-1:0]      r;
        logic [NREQ*DATA-1:0] rd;
        logic [NREQ-1:0]      rl;
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        forever begin
            @(posedge wclk);
            #1;
            r  = '0;
            rd = '0;
            rl = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (ack_s[i] && src[i].size() > 0) void'(src[i].pop_front());
                if (en[i] && src[i].size() > 0) begin
                    r[i]              = 1'b1;
                    rd[i*DATA +: DATA] = src[i][0].d;
                    rl[i]             = src[i][0].l;
                end
            end
            if (bus.req == '0 && r != '0) t_req = cyc;
            bus.req      = r;
            bus.req_data = rd;
            bus.req_last = rl;
        end
    end

    // Monitor / scoreboard.
    initial begin
        exp_t            e;
        logic [NREQ-1:0] oh;
        forever begin
            @(negedge wclk);
            ack_s = bus.ack;
            if (bus.fifo_full) check("write_while_full", 32'(bus.fifo_w_en), 32'd0);
            if (bus.busy && !bus.fifo_w_en) check("ack_without_write", 32'(bus.ack), 32'd0);
            if (bus.fifo_w_en) begin
                stamps.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got data %0h, expected no write", bus.fifo_data_in);
                end else begin
                    e  = exp_q.pop_front();
                    oh = NREQ'(1) << e.idx;
                    check("wr_data", 32'(bus.fifo_data_in), 32'(e.d));
                    check("ack", 32'(bus.ack), 32'(oh));
                    check("grant_on_write", 32'(bus.grant), 32'(oh));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge wclk);
            if (!rst_w && wbus.fifo_w_en) begin
                if (wn == 65535) check("wrap_ffff", 32'(wbus.wr_count), 32'h0000_ffff);
                if (wn == 65536) check("wrap_0000", 32'(wbus.wr_count), 32'h0000_0000);
                if (wn == 65537) check("wrap_0001", 32'(wbus.wr_count), 32'h0000_0001);
                wn++;
                if (wn == 65538) wrap_done = 1'b1;
            end
        end
    end

    initial begin
        int off[8];
        int budget;
        bus.fifo_full = 1'b0;

        // Reset state.
        @(negedge wclk);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_w_en", 32'(bus.fifo_w_en), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_data", 32'(bus.fifo_data_in), 32'd0);
        check("rst_wr_count", 32'(bus.wr_count), 32'd0);
        @(posedge wclk);
        #3;
        rst   = 1'b0;
        rst_w = 1'b0;

        // Single requester, 6 words, no req_last.
        for (int j = 0; j < 6; j++) push(0, DATA'(14'h0011 + j), 1'b0, 1'b1);
        en = 4'b0001;
        wait_writes("single", 6, 40);
        check("single_latency", 32'(stamps[0] - t_req), 32'd1);
        off = '{0, 1, 2, 3, 5, 6, 0, 0};
        check_offs("single_offs", 6, off);
        settle("single");
        check("single_wr_count", 32'(bus.wr_count), 32'd6);
        en = '0;

        // Reset in the middle of a burst of requester 2.
        for (int j = 0; j < 4; j++) push(2, DATA'(14'h0200 + j), 1'b0, j < 2);
        en = 4'b0100;
        wait_writes("rstmid", 2, 20);
        @(posedge wclk);
        #2;
        check("rstmid_pre_w_en", 32'(bus.fifo_w_en), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rstmid_w_en", 32'(bus.fifo_w_en), 32'd0);
        check("rstmid_ack", 32'(bus.ack), 32'd0);
        check("rstmid_grant", 32'(bus.grant), 32'd0);
        check("rstmid_wr_count", 32'(bus.wr_count), 32'd0);
        en = '0;
        for (int i = 0; i < NREQ; i++) src[i].delete();
        exp_q.delete();
        stamps.delete();
        repeat (2) @(posedge wclk);
        #3;
        rst = 1'b0;

        // Round robin with req_last on every word: 0,1,2,3,0,1,2,3.
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < NREQ; i++) push(i, DATA'(14'h0100 + 16 * i + j), 1'b1, 1'b1);
        en = 4'b1111;
        wait_writes("rr", 8, 60);
        off = '{0, 2, 4, 6, 8, 10, 12, 14};
        check_offs("rr_offs", 8, off);
        settle("rr");
        en = '0;

        // Back-pressure mid-burst on requester 2.
        for (int j = 0; j < 6; j++) push(2, DATA'(14'h0a00 + j), 1'b0, 1'b1);
        en = 4'b0100;
        wait_writes("full_pre", 2, 20);
        @(posedge wclk);
        #1;
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge wclk);
            check("full_grant", 32'(bus.grant), 32'h4);
            check("full_busy", 32'(bus.busy), 32'd1);
            check("full_w_en", 32'(bus.fifo_w_en), 32'd0);
            @(posedge wclk);
            #1;
        end
        bus.fifo_full = 1'b0;
        wait_writes("full", 6, 40);
        off = '{0, 1, 7, 8, 10, 11, 0, 0};
        check_offs("full_offs", 6, off);
        settle("full");
        en = '0;

        // Owner 1 withdraws after 2 acks; requester 2 is next.
        for (int j = 0; j < 4; j++) push(1, DATA'(14'h0110 + j), 1'b0, j < 2);
        for (int j = 0; j < 2; j++) push(2, DATA'(14'h0220 + j), 1'b0, 1'b1);
        en = 4'b0110;
        wait_writes("wd_pre", 2, 20);
        en = 4'b0100;
        wait_writes("wd", 4, 30);
        off = '{0, 1, 4, 5, 0, 0, 0, 0};
        check_offs("wd_offs", 4, off);
        settle("wd");
        en = '0;
        src[1].delete();

        // req_last on word 2, then req_last coinciding with a full burst.
        push(3, 14'h0300, 1'b0, 1'b1);
        push(3, 14'h0301, 1'b1, 1'b1);
        push(3, 14'h0302, 1'b0, 1'b1);
        push(3, 14'h0303, 1'b0, 1'b1);
        push(3, 14'h0304, 1'b0, 1'b1);
        push(3, 14'h0305, 1'b1, 1'b1);
        push(3, 14'h0306, 1'b0, 1'b1);
        en = 4'b1000;
        wait_writes("last", 7, 40);
        off = '{0, 1, 3, 4, 5, 6, 8, 0};
        check_offs("last_offs", 7, off);
        settle("last");
        en = '0;
        check("final_wr_count", 32'(bus.wr_count), 32'd25);

        budget = 90000;
        while (!wrap_done && budget > 0) begin
            @(negedge wclk);
            budget--;
        end
        check("wrap_timeout", 32'(wrap_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that lets NREQ producers share the single write port of the asynchronous FIFO on the write-clock domain. It grants one requester at a time for a bounded burst and gates every word against the FIFO `full` flag. It drives `w_en`/`data_in` of the FIFO directly and returns a per-word acknowledge to the granted producer.

## Interface
- `DATA`, 14, word width; matches FIFO `data`
- `NREQ`, 4, number of requesters (2..8)
- `MAX_BURST`, 4, maximum words per grant (1..15)
- `wclk`  in  1  write-domain clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  NREQ  per-requester word valid
- `req_data`  in  NREQ*DATA  packed words; requester i at bits [i*DATA +: DATA]
- `req_last`  in  NREQ  marks the final word of requester i's burst
- `fifo_full`  in  1  FIFO full flag, write domain
- `fifo_w_en`  out  1  FIFO write enable
- `fifo_data_in`  out  DATA  FIFO write data
- `ack`  out  NREQ  one-hot; word of requester i accepted this cycle
- `grant`  out  NREQ  registered one-hot owner; 0 when idle
- `busy`  out  1  state is GRANT
- `wr_count`  out  16  total words written; wraps at 2^16

## Operation
- FSM has two states: IDLE and GRANT. The owner index is `own`, the round-robin pointer is `last`, and the beat counter is `beat`, sized to hold MAX_BURST.
- IDLE: if `req` != 0 at a rising edge, the next owner is the first requester with `req` set, searching from (`last`+1) mod NREQ upward with wrap. The FSM then loads `own`, sets `grant` one-hot, clears `beat` and goes to GRANT. If `req` == 0, it stays in IDLE.
- GRANT, combinational outputs:
  - xfer = `req[own]` & !`fifo_full`
  - `fifo_w_en` = xfer
  - `fifo_data_in` = word `own` of `req_data` (driven whenever in GRANT; 0 in IDLE)
  - `ack` = xfer ? one-hot(`own`) : 0
- GRANT, at each rising edge:
  - on xfer: `beat` increments and `wr_count` increments.
  - Release when any of these holds:
    - xfer & `req_last[own]`
    - xfer & (`beat`+1 == MAX_BURST)
    - !`req[own]`, meaning the owner withdrew
  - On release: `last` <= `own`, `grant` <= 0, state <= IDLE.
- `fifo_full` high in GRANT: no write, no ack, `beat` holds, grant held indefinitely. There is no timeout.
- Requests from non-owners are ignored until the next IDLE arbitration. Their `ack` stays 0.
- A requester must hold `req` and its data stable until it sees `ack`. Deasserting `req` before `ack` forfeits the grant.
- The arbiter guarantees that a write is never issued while `fifo_full` is high.

## Timing
- Reset (async, immediate): state IDLE, `grant`=0, `busy`=0, `own`=0, `last`=NREQ-1 (requester 0 has first priority), `beat`=0, `wr_count`=0.
- While reset is asserted, `fifo_w_en`=0, `ack`=0 and `fifo_data_in`=0 combinationally.
- Request to first write: 1 cycle. Edge N samples `req` in IDLE; `grant` is valid after edge N; the first word is written at edge N+1 if the FIFO is not full.
- Idle bubble: every release costs exactly one IDLE cycle before the next grant. Peak throughput is MAX_BURST words per MAX_BURST+1 cycles.
- `req_last` together with `beat`+1 == MAX_BURST on the same word causes a single release, with no double count.
- The owner dropping `req` in the same cycle as `fifo_full` releases at that edge with no write.
- Reset mid-burst aborts immediately. The current-cycle word is not written, and `wr_count` is not incremented for it.
- `wr_count` wraps from 0xFFFF to 0x0000 with no flag.

## Test plan
- Reset mid-burst: assert `rst` while granted -> `fifo_w_en` falls within the same cycle, `grant`=0, `wr_count`=0. After release, requester 0 wins first.
- Single requester: `req`=0001 held, data 0x0011..0x0016, no `req_last`, FIFO empty -> grant 0001 after 1 cycle. Writes 0x0011..0x0014 on 4 consecutive edges, then 1 IDLE cycle, then 0x0015, 0x0016. `wr_count`=6.
- Round-robin fairness: `req`=1111 constantly, `req_last` on every word -> grants 0001, 0010, 0100, 1000, 0001 in order, each with 1 word followed by 1 IDLE cycle.
- Full back-pressure: grant to requester 2, `fifo_full` high for 5 cycles mid-burst -> `fifo_w_en`=0 and `ack`=0 for those 5 cycles. `grant` stays 0100, `beat` holds, and the burst completes with MAX_BURST total words.
- Withdrawal and `req_last`: owner 1 drops `req` after 2 acks -> release, `last`=1, next grant goes to requester 2 if requesting. Separately, `req_last` on the 2nd word -> release after 2 words.
- Counter wrap: preload by writing 65535 words, then 2 more -> `wr_count` goes 0xFFFF, 0x0000, 0x0001.
